// File: rtl/spi_target_if.sv
// Signal bundle between the SPI target and its surroundings: SPI pins plus the
// byte-level receive and transmit handshakes.
interface spi_target_if;
    logic       spi_sck_i;
    logic       spi_mosi_i;
    logic       spi_miso_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       tx_underrun_o;
    logic       frame_err_o;

    modport master (
        output spi_sck_i, spi_mosi_i, tx_data_i, tx_valid_i,
        input  spi_miso_o, rx_data_o, rx_valid_o, tx_ready_o, tx_underrun_o, frame_err_o
    );

    modport slave (
        input  spi_sck_i, spi_mosi_i, tx_data_i, tx_valid_i,
        output spi_miso_o, rx_data_o, rx_valid_o, tx_ready_o, tx_underrun_o, frame_err_o
    );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target oversampled in the system clock domain; byte framing is
// recovered from an SCK idle timeout since the controller has no chip select.
module spi_target #(
    parameter int         IdleTimeout = 64,
    parameter logic [7:0] TxIdleByte  = 8'hFF
) (
    input  logic         clk_sys_i,
    input  logic         rst_sys_i,
    spi_target_if.slave  bus
);
    localparam logic [15:0] IDLE_LIM = 16'(IdleTimeout);

    logic       sck_p0, sck_p1, sck_p2;
    logic       mosi_p0, mosi_p1;
    logic       sck_rise, sck_fall;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] hold_data;
    logic       hold_valid;
    logic [7:0] tx_shift;
    logic       tx_armed;
    logic       tx_underrun;
    logic       frame_err;
    logic [15:0] idle_cnt;
    logic       accept, load_now, timeout;

    // Pin synchronisers; the third SCK flop feeds the edge detectors
    always_ff @(posedge clk_sys_i) begin
        sck_p0  <= bus.spi_sck_i;
        sck_p1  <= sck_p0;
        sck_p2  <= sck_p1;
        mosi_p0 <= bus.spi_mosi_i;
        mosi_p1 <= mosi_p0;
    end

    assign sck_rise = sck_p1 & ~sck_p2;
    assign sck_fall = ~sck_p1 & sck_p2;

    // Reload only while SCK is low so a byte staged during the last high phase
    // is not thrown away by the closing falling edge.
    assign accept   = bus.tx_valid_i && !hold_valid;
    assign load_now = (bit_cnt == 3'd0) && !tx_armed && !sck_rise && !sck_p2;
    assign timeout  = (bit_cnt != 3'd0) && !sck_rise && !sck_fall && (idle_cnt >= IDLE_LIM);

    // Byte engine: bit counting, shifting, holding register and timeout
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            bit_cnt     <= 3'd0;
            tx_armed    <= 1'b0;
            hold_valid  <= 1'b0;
            idle_cnt    <= 16'd0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            rx_data     <= 8'h00;
            rx_shift    <= 8'h00;
            tx_shift    <= TxIdleByte;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;

            if (sck_rise || sck_fall)
                idle_cnt <= 16'd0;
            else if (idle_cnt != 16'hFFFF)
                idle_cnt <= idle_cnt + 16'd1;

            if (accept) begin
                hold_data  <= bus.tx_data_i;
                hold_valid <= 1'b1;
            end

            if (sck_rise) begin
                rx_shift <= {rx_shift[6:0], mosi_p1};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data  <= {rx_shift[6:0], mosi_p1};
                    rx_valid <= 1'b1;
                end
                if (bit_cnt == 3'd0 && !tx_armed)
                    tx_underrun <= 1'b1;
            end else if (timeout) begin
                bit_cnt   <= 3'd0;
                rx_shift  <= 8'h00;
                tx_armed  <= 1'b0;
                frame_err <= 1'b1;
            end

            if (sck_fall) begin
                if (bit_cnt != 3'd0)
                    tx_shift <= {tx_shift[6:0], 1'b1};
                else
                    tx_armed <= 1'b0;
            end else if (load_now) begin
                if (hold_valid) begin
                    tx_shift   <= hold_data;
                    tx_armed   <= 1'b1;
                    hold_valid <= 1'b0;
                end else begin
                    tx_shift <= TxIdleByte;
                end
            end
        end
    end

    assign bus.spi_miso_o    = tx_shift[7];
    assign bus.rx_data_o     = rx_data;
    assign bus.rx_valid_o    = rx_valid;
    assign bus.tx_ready_o    = !hold_valid;
    assign bus.tx_underrun_o = tx_underrun;
    assign bus.frame_err_o   = frame_err;
endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a bit-banged mode-0 controller drives SCK/MOSI while a
// scoreboard matches every rx_valid_o pulse against the bytes that were sent.
module tb_spi_target;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_target_if bus();

    spi_target #(.IdleTimeout(64), .TxIdleByte(8'hFF)) dut (
        .clk_sys_i (clk),
        .rst_sys_i (rst),
        .bus       (bus.slave)
    );

    int n_cmp  = 0;
    int n_err  = 0;
    int uf_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] exp_q[$];

    // One clock; sample just after the edge, count pulses, score received bytes
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (bus.tx_underrun_o === 1'b1) uf_cnt++;
        if (bus.frame_err_o === 1'b1) fe_cnt++;
        if (bus.rx_valid_o === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rx_unexpected: got %h, required no byte", bus.rx_data_o);
            end else begin
                e = exp_q.pop_front();
                if (bus.rx_data_o !== e) begin
                    n_err++;
                    $display("FAIL rx_data: got %h, required %h", bus.rx_data_o, e);
                end
            end
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic queue_tx(input logic [7:0] d);
        int t = 0;
        while (bus.tx_ready_o !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL queue_tx_wait: tx_ready=%b, required 1 within 200 cycles", bus.tx_ready_o);
        end
        bus.tx_data_i  = d;
        bus.tx_valid_i = 1'b1;
        tick();
        bus.tx_valid_i = 1'b0;
    endtask

    // Mode 0: MOSI set during low phase, MISO sampled just before the rise
    task automatic send_bits(input logic [7:0] d, input int nbits, input bit late_en,
                             input logic [7:0] late_d, output logic [7:0] m);
        m = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi_i = d[7-i];
            ticks(H);
            m = {m[6:0], bus.spi_miso_o};
            bus.spi_sck_i = 1'b1;
            for (int j = 0; j < H; j++) begin
                tick();
                if (late_en && i == 0 && j == 3) begin
                    bus.tx_data_i  = late_d;
                    bus.tx_valid_i = 1'b1;
                end else begin
                    bus.tx_valid_i = 1'b0;
                end
            end
            bus.spi_sck_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(3);
        n_cmp += 6;
        if (bus.spi_miso_o !== 1'b1) begin n_err++; $display("FAIL rst_miso: got %b, required 1", bus.spi_miso_o); end
        if (bus.rx_data_o !== 8'h00) begin n_err++; $display("FAIL rst_rx_data: got %h, required 00", bus.rx_data_o); end
        if (bus.rx_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_rx_valid: got %b, required 0", bus.rx_valid_o); end
        if (bus.tx_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_tx_ready: got %b, required 1", bus.tx_ready_o); end
        if (bus.tx_underrun_o !== 1'b0) begin n_err++; $display("FAIL rst_underrun: got %b, required 0", bus.tx_underrun_o); end
        if (bus.frame_err_o !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %b, required 0", bus.frame_err_o); end
        rst = 1'b0;
        ticks(4);
    endtask

    task automatic test_receive();
        logic [7:0] m;
        int uf0 = uf_cnt;
        exp_q.push_back(8'hA5);
        send_bits(8'hA5, 8, 1'b0, 8'h00, m);
        ticks(12);
        n_cmp += 3;
        if (m !== 8'hFF) begin n_err++; $display("FAIL recv_miso: got %h, required ff", m); end
        if (uf_cnt - uf0 != 1) begin n_err++; $display("FAIL recv_underrun: got %0d pulses, required 1", uf_cnt - uf0); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL recv_missing: got %0d bytes outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_tx_queued();
        logic [7:0] m;
        int uf0 = uf_cnt;
        queue_tx(8'h3C);
        ticks(2);
        n_cmp += 2;
        if (bus.tx_ready_o !== 1'b1) begin n_err++; $display("FAIL txq_ready: got %b, required 1", bus.tx_ready_o); end
        if (bus.spi_miso_o !== 1'b0) begin n_err++; $display("FAIL txq_first_bit: got %b, required 0", bus.spi_miso_o); end
        exp_q.push_back(8'h96);
        send_bits(8'h96, 8, 1'b0, 8'h00, m);
        ticks(12);
        n_cmp += 3;
        if (m !== 8'h3C) begin n_err++; $display("FAIL txq_miso: got %h, required 3c", m); end
        if (uf_cnt != uf0) begin n_err++; $display("FAIL txq_underrun: got %0d pulses, required 0", uf_cnt - uf0); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL txq_missing: got %0d bytes outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m1, m2;
        int uf0 = uf_cnt;
        queue_tx(8'h12);
        queue_tx(8'h34);
        n_cmp++;
        if (bus.tx_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_hold_full: got %b, required 0", bus.tx_ready_o); end
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h81);
        send_bits(8'hC3, 8, 1'b0, 8'h00, m1);
        send_bits(8'h81, 8, 1'b0, 8'h00, m2);
        ticks(12);
        n_cmp += 5;
        if (m1 !== 8'h12) begin n_err++; $display("FAIL b2b_miso1: got %h, required 12", m1); end
        if (m2 !== 8'h34) begin n_err++; $display("FAIL b2b_miso2: got %h, required 34", m2); end
        if (uf_cnt != uf0) begin n_err++; $display("FAIL b2b_underrun: got %0d pulses, required 0", uf_cnt - uf0); end
        if (bus.tx_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready_end: got %b, required 1", bus.tx_ready_o); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_missing: got %0d bytes outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_late_data();
        logic [7:0] m1, m2;
        int uf0 = uf_cnt;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_bits(8'h55, 8, 1'b1, 8'h9E, m1);
        send_bits(8'hAA, 8, 1'b0, 8'h00, m2);
        ticks(12);
        n_cmp += 4;
        if (m1 !== 8'hFF) begin n_err++; $display("FAIL late_miso1: got %h, required ff", m1); end
        if (m2 !== 8'h9E) begin n_err++; $display("FAIL late_miso2: got %h, required 9e", m2); end
        if (uf_cnt - uf0 != 1) begin n_err++; $display("FAIL late_underrun: got %0d pulses, required 1", uf_cnt - uf0); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL late_missing: got %0d bytes outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        logic [7:0] m;
        int fe0 = fe_cnt;
        send_bits(8'hE0, 3, 1'b0, 8'h00, m);
        ticks(100);
        n_cmp++;
        if (fe_cnt - fe0 != 1) begin n_err++; $display("FAIL tmo_frame_err: got %0d pulses, required 1", fe_cnt - fe0); end
        exp_q.push_back(8'h5A);
        send_bits(8'h5A, 8, 1'b0, 8'h00, m);
        ticks(12);
        n_cmp += 3;
        if (m !== 8'hFF) begin n_err++; $display("FAIL tmo_miso: got %h, required ff", m); end
        if (fe_cnt - fe0 != 1) begin n_err++; $display("FAIL tmo_frame_err_after: got %0d pulses, required 1", fe_cnt - fe0); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL tmo_missing: got %0d bytes outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] m;
        int fe0 = fe_cnt;
        send_bits(8'hAA, 5, 1'b0, 8'h00, m);
        queue_tx(8'h77);
        n_cmp++;
        if (bus.tx_ready_o !== 1'b0) begin n_err++; $display("FAIL rmid_hold_full: got %b, required 0", bus.tx_ready_o); end
        rst = 1'b1;
        ticks(2);
        n_cmp += 5;
        if (bus.spi_miso_o !== 1'b1) begin n_err++; $display("FAIL rmid_miso: got %b, required 1", bus.spi_miso_o); end
        if (bus.rx_data_o !== 8'h00) begin n_err++; $display("FAIL rmid_rx_data: got %h, required 00", bus.rx_data_o); end
        if (bus.rx_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_rx_valid: got %b, required 0", bus.rx_valid_o); end
        if (bus.tx_ready_o !== 1'b1) begin n_err++; $display("FAIL rmid_tx_ready: got %b, required 1", bus.tx_ready_o); end
        if (bus.frame_err_o !== 1'b0) begin n_err++; $display("FAIL rmid_frame_err: got %b, required 0", bus.frame_err_o); end
        rst = 1'b0;
        ticks(3);
        exp_q.push_back(8'hF0);
        send_bits(8'hF0, 8, 1'b0, 8'h00, m);
        ticks(12);
        n_cmp += 3;
        if (m !== 8'hFF) begin n_err++; $display("FAIL rmid_miso_after: got %h, required ff", m); end
        if (fe_cnt != fe0) begin n_err++; $display("FAIL rmid_frame_err_after: got %0d pulses, required 0", fe_cnt - fe0); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL rmid_missing: got %0d bytes outstanding, required 0", exp_q.size()); end
    endtask

    initial begin
        rst            = 1'b1;
        bus.spi_sck_i  = 1'b0;
        bus.spi_mosi_i = 1'b0;
        bus.tx_data_i  = 8'h00;
        bus.tx_valid_i = 1'b0;
        test_reset();
        test_receive();
        test_tx_queued();
        test_back_to_back();
        test_late_data();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
